// File: rtl/axi_err_pkg.sv
// Shared definitions for the AXI write-path error responder.
// Holds the responder FSM encoding and the AXI response codes it uses.
package axi_err_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        W_DONE = 2'd2,
        RESP   = 2'd3
    } err_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_aw_error_responder.sv
// Terminates write bursts that decoded to no slave: captures the AW
// attributes, sinks exactly AWLEN+1 W beats, then returns one DECERR on B.
// Optional build macro AXI_ERR_WLAST_CHECK_EN adds a sticky check that
// WLAST lines up with the AWLEN-derived last beat.
module axi_aw_error_responder
    import axi_err_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_awdata_info_i,
    input  logic [AXI_ID_WIDTH-1:0]   awid_i,
    input  logic [7:0]                awlen_i,
    input  logic [AXI_USER_WIDTH-1:0] awuser_i,
    input  logic                      handle_error_i,
    input  logic                      wvalid_i,
    input  logic                      wlast_i,
    output logic                      wready_o,
    output logic                      wdata_error_completed_o,
    input  logic                      error_req_i,
    output logic                      error_gnt_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    output logic [AXI_ID_WIDTH-1:0]   bid_o,
    output logic [1:0]                bresp_o,
    output logic [AXI_USER_WIDTH-1:0] buser_o,
    output logic                      wlast_err_o
);

    err_state_e                state_q, state_d;
    logic [7:0]                awlen_q;
    logic [8:0]                beat_cnt_q;  // 9 bits so awlen=255 never wraps
    logic [AXI_ID_WIDTH-1:0]   bid_q;
    logic [AXI_USER_WIDTH-1:0] buser_q;
    logic [1:0]                bresp_q;
    logic                      beat_acc;
    logic                      last_beat;

    // Termination is purely length based; WLAST is never consulted here.
    assign beat_acc  = wvalid_i & wready_o;
    assign last_beat = (beat_cnt_q == {1'b0, awlen_q});

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus handshake outputs, all decoded from state and inputs.
    always_comb begin
        state_d                 = state_q;
        wready_o                = 1'b0;
        wdata_error_completed_o = 1'b0;
        bvalid_o                = 1'b0;
        error_gnt_o             = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_awdata_info_i) state_d = DRAIN;
            end
            DRAIN: begin
                wready_o = handle_error_i;
                if (wvalid_i && handle_error_i && last_beat) state_d = W_DONE;
            end
            W_DONE: begin
                wdata_error_completed_o = 1'b1;
                state_d                 = RESP;
            end
            RESP: begin
                // The decoder holds error_req until granted, so bvalid is stable.
                bvalid_o    = error_req_i;
                error_gnt_o = error_req_i & bready_i;
                if (error_req_i && bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Attribute capture on the sample strobe (IDLE only) and beat counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awlen_q    <= '0;
            beat_cnt_q <= '0;
            bid_q      <= '0;
            buser_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else if (state_q == IDLE && sample_awdata_info_i) begin
            awlen_q    <= awlen_i;
            beat_cnt_q <= '0;
            bid_q      <= awid_i;
            buser_q    <= awuser_i;
            bresp_q    <= RESP_DECERR;
        end else if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
        end
    end

    assign bid_o   = bid_q;
    assign buser_o = buser_q;
    assign bresp_o = bresp_q;

`ifdef AXI_ERR_WLAST_CHECK_EN
    logic wlast_err_q;

    // Sticky flag: any drained beat whose WLAST disagrees with the length.
    always_ff @(posedge clk) begin
        if (!rst_n)                             wlast_err_q <= 1'b0;
        else if (beat_acc && (wlast_i != last_beat)) wlast_err_q <= 1'b1;
    end

    assign wlast_err_o = wlast_err_q;
`else
    logic unused_wlast;

    assign unused_wlast = wlast_i;
    assign wlast_err_o  = 1'b0;
`endif

endmodule
